// File: rtl/unison_pkg.sv
// Shared constants, serializer state type and frame builder for the
// unison bank readout path.
package unison_pkg;

    localparam int FRAME_LEN = 10;
    localparam int ID_W      = 3;
    localparam int SAMPLE_W  = 4;
    localparam int ENTRY_W   = ID_W + SAMPLE_W;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

    typedef enum logic {
        IDLE,
        SHIFT
    } ser_state_e;

    // Entry is {id, I1, I0, Q1, Q0}; XOR of the entry makes the total count of ones even.
    function automatic logic [FRAME_LEN-1:0] build_frame(input logic [ENTRY_W-1:0] entry);
        return {START_BIT, entry, ^entry, STOP_BIT};
    endfunction

endpackage

// File: rtl/unison_sample_fifo.sv
// Small synchronous FIFO holding tagged bank samples; head entry is visible
// combinationally so the serializer can load it on the pop edge.
module unison_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;

endmodule

// File: rtl/unison_readout_arbiter.sv
// Round-robin grant of bank samples into a tagged FIFO, drained by a
// 10-bit framed serializer onto a single output pin.
module unison_readout_arbiter
    import unison_pkg::*;
#(
    parameter int NUM_BANKS  = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_master,
    input  logic                          rstb,
    input  logic                          en,
    input  logic [NUM_BANKS-1:0]          bank_valid,
    input  logic [4*NUM_BANKS-1:0]        bank_data,
    output logic [NUM_BANKS-1:0]          bank_ack,
    output logic                          ser_out,
    output logic                          ser_frame,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ID_W-1:0] LAST_BANK = ID_W'(NUM_BANKS - 1);
    localparam logic [ID_W:0]   NB_EXT    = (ID_W + 1)'(NUM_BANKS);

    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [NUM_BANKS-1:0] ack_q, ack_d;
    logic [7:0]           elig8;
    logic [SAMPLE_W-1:0]  bank_sample [8];
    logic                 found;
    logic [ID_W-1:0]      gnt_idx;
    logic [ID_W:0]        sum;
    logic                 push, pop;
    logic [ENTRY_W-1:0]   fifo_rdata;
    logic                 fifo_full, fifo_empty;

    ser_state_e           state_q, state_d;
    logic [FRAME_LEN-1:0] shreg_q, shreg_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 ser_out_q, ser_out_d;
    logic                 ser_frame_q, ser_frame_d;
    logic                 busy_q, busy_d;
    logic                 load;
    logic [FRAME_LEN-1:0] frame;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_sample
            if (gi < NUM_BANKS) begin : g_used
                assign bank_sample[gi] = bank_data[4*gi +: SAMPLE_W];
            end else begin : g_unused
                assign bank_sample[gi] = '0;
            end
        end
    endgenerate

    // A bank whose ack is still high has already been served this sample.
    assign elig8 = 8'(bank_valid & ~ack_q);

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            sum = {1'b0, ptr_q} + (ID_W + 1)'(i);
            if (sum >= NB_EXT) sum = sum - NB_EXT;
            if (!found && elig8[sum[ID_W-1:0]]) begin
                found   = 1'b1;
                gnt_idx = sum[ID_W-1:0];
            end
        end
        push  = en && !fifo_full && found;
        ptr_d = ptr_q;
        ack_d = '0;
        if (push) begin
            ptr_d          = (gnt_idx == LAST_BANK) ? '0 : gnt_idx + ID_W'(1);
            ack_d[gnt_idx] = 1'b1;
        end
    end

    unison_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk_master),
        .rst_n (rstb),
        .push  (push),
        .wdata ({gnt_idx, bank_sample[gnt_idx]}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        ser_out_d   = ser_out_q;
        ser_frame_d = ser_frame_q;
        load        = 1'b0;
        frame       = build_frame(fifo_rdata);
        case (state_q)
            IDLE: load = !fifo_empty;
            SHIFT: begin
                if (bit_cnt_q == 4'(FRAME_LEN - 1)) begin
                    // Reloading on the stop-bit edge keeps frames gapless.
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        ser_out_d   = 1'b0;
                        ser_frame_d = 1'b0;
                    end
                end else begin
                    ser_out_d = shreg_q[FRAME_LEN-1];
                    shreg_d   = {shreg_q[FRAME_LEN-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d     = SHIFT;
            ser_out_d   = frame[FRAME_LEN-1];
            ser_frame_d = 1'b1;
            shreg_d     = {frame[FRAME_LEN-2:0], 1'b0};
            bit_cnt_d   = '0;
        end
        pop    = load;
        busy_d = push || (fifo_level > LW'(1)) || (fifo_level == LW'(1) && !pop) ||
                 (state_d == SHIFT);
    end

    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            ptr_q       <= '0;
            ack_q       <= '0;
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            ser_out_q   <= 1'b0;
            ser_frame_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            ack_q       <= ack_d;
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            ser_out_q   <= ser_out_d;
            ser_frame_q <= ser_frame_d;
            busy_q      <= busy_d;
        end
    end

    assign bank_ack  = ack_q;
    assign ser_out   = ser_out_q;
    assign ser_frame = ser_frame_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_unison_readout_arbiter.sv
// Directed bench for the readout arbiter: round robin, backpressure, single
// sample framing, enable gating and asynchronous reset mid-frame.
module tb_unison_readout_arbiter;

    logic        clk_master = 1'b0;
    logic        rstb;
    logic        en;
    logic [5:0]  bank_valid;
    logic [23:0] bank_data;
    logic [5:0]  bank_ack;
    logic        ser_out;
    logic        ser_frame;
    logic [2:0]  fifo_level;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int          ack_log [$];
    logic [9:0]  frame_log [$];

    unison_readout_arbiter dut (
        .clk_master (clk_master),
        .rstb       (rstb),
        .en         (en),
        .bank_valid (bank_valid),
        .bank_data  (bank_data),
        .bank_ack   (bank_ack),
        .ser_out    (ser_out),
        .ser_frame  (ser_frame),
        .fifo_level (fifo_level),
        .busy       (busy)
    );

    always #5 clk_master = ~clk_master;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk_master);
        #2;
    endtask

    // Monitor: logs granted bank numbers and completed frames.
    initial begin
        logic [9:0] acc;
        int         nbits;
        acc   = '0;
        nbits = 0;
        forever begin
            @(posedge clk_master);
            #1;
            if (!rstb) begin
                acc   = '0;
                nbits = 0;
            end else begin
                for (int k = 0; k < 6; k++)
                    if (bank_ack[k]) ack_log.push_back(k);
                if (ser_frame) begin
                    acc = {acc[8:0], ser_out};
                    nbits++;
                    if (nbits == 10) begin
                        frame_log.push_back(acc);
                        nbits = 0;
                    end
                end else begin
                    nbits = 0;
                end
            end
        end
    end

    initial begin
        int         ab, fb, n, run;
        bit         seen;
        int         exp_ids [7];
        logic [9:0] exp_frames [7];

        exp_ids    = '{0, 1, 2, 3, 4, 5, 0};
        exp_frames = '{10'h214, 10'h26A, 10'h28E, 10'h2EE, 10'h31A, 10'h37A, 10'h214};

        rstb       = 1'b0;
        en         = 1'b0;
        bank_valid = '0;
        // Banks 5..0 hold E, 6, B, 3, A, 5.
        bank_data  = {4'hE, 4'h6, 4'hB, 4'h3, 4'hA, 4'h5};
        repeat (3) @(posedge clk_master);
        #2;
        chk("rst_ack", 32'(bank_ack), 0);
        chk("rst_ser_out", 32'(ser_out), 0);
        chk("rst_ser_frame", 32'(ser_frame), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_busy", 32'(busy), 0);
        rstb = 1'b1;
        en   = 1'b1;
        tick();

        // Round robin with backpressure.
        bank_valid = 6'b111111;
        tick();
        chk("rr_first_ack", 32'(bank_ack), 32'h01);
        repeat (4) tick();
        chk("bp_level_full", 32'(fifo_level), 4);
        repeat (6) tick();
        chk("bp_level_hold", 32'(fifo_level), 4);
        chk("bp_no_ack_full", 32'(ack_log.size()), 5);
        tick();
        chk("bp_level_after_pop", 32'(fifo_level), 3);
        chk("bp_ack_pop_edge", 32'(bank_ack), 0);
        tick();
        chk("bp_ack_after_pop", 32'(bank_ack), 32'h20);
        chk("bp_level_refill", 32'(fifo_level), 4);
        n = 0;
        while (ack_log.size() < 7 && n < 40) begin
            tick();
            n++;
        end
        bank_valid = '0;
        chk("rr_seven_acks", 32'(ack_log.size() >= 7), 1);
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk("rr_drain_busy", 32'(busy), 0);
        chk("rr_frame_count", 32'(frame_log.size()), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < ack_log.size()) chk($sformatf("rr_ack%0d", i), 32'(ack_log[i]), 32'(exp_ids[i]));
            if (i < frame_log.size()) chk($sformatf("rr_frame%0d", i), 32'(frame_log[i]), 32'(exp_frames[i]));
        end

        // Single sample from bank 3.
        ab = ack_log.size();
        fb = frame_log.size();
        bank_valid = 6'b001000;
        tick();
        chk("sb_ack", 32'(bank_ack), 32'h08);
        chk("sb_level", 32'(fifo_level), 1);
        chk("sb_busy", 32'(busy), 1);
        chk("sb_frame_idle", 32'(ser_frame), 0);
        bank_valid = '0;
        tick();
        chk("sb_ack_pulse", 32'(bank_ack), 0);
        chk("sb_start_frame", 32'(ser_frame), 1);
        chk("sb_start_bit", 32'(ser_out), 1);
        chk("sb_level_pop", 32'(fifo_level), 0);
        repeat (9) tick();
        chk("sb_stop_bit", 32'(ser_out), 0);
        chk("sb_stop_frame", 32'(ser_frame), 1);
        tick();
        chk("sb_end_frame", 32'(ser_frame), 0);
        chk("sb_end_busy", 32'(busy), 0);
        chk("sb_ack_count", 32'(ack_log.size()), 32'(ab + 1));
        chk("sb_frame_count", 32'(frame_log.size()), 32'(fb + 1));
        if (frame_log.size() > fb) chk("sb_frame", 32'(frame_log[fb]), 32'h2EE);

        // Enable low: pointer is at 4, banks 1 and 2 queued, then en drops.
        ab = ack_log.size();
        fb = frame_log.size();
        bank_valid = 6'b000110;
        tick();
        chk("en_ack_b1", 32'(bank_ack), 32'h02);
        tick();
        chk("en_ack_b2", 32'(bank_ack), 32'h04);
        en         = 1'b0;
        bank_valid = 6'b111111;
        run  = ser_frame ? 1 : 0;
        seen = ser_frame;
        n    = 0;
        while (n < 60) begin
            tick();
            n++;
            if (ser_frame) begin
                run++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
        end
        chk("b2b_frame_run", 32'(run), 20);
        chk("en_no_acks", 32'(ack_log.size()), 32'(ab + 2));
        chk("en_frame_count", 32'(frame_log.size()), 32'(fb + 2));
        if (frame_log.size() > fb + 1) begin
            chk("en_frame_b1", 32'(frame_log[fb]), 32'h26A);
            chk("en_frame_b2", 32'(frame_log[fb + 1]), 32'h28E);
        end
        chk("en_busy_idle", 32'(busy), 0);
        en = 1'b1;
        tick();
        chk("en_resume_b3", 32'(bank_ack), 32'h08);

        // Queue two more, then reset during frame bit 5 of bank 3's frame.
        bank_valid = 6'b110000;
        tick();
        tick();
        chk("rs_ack_b5", 32'(bank_ack), 32'h20);
        bank_valid = '0;
        repeat (4) tick();
        chk("rs_pre_frame", 32'(ser_frame), 1);
        chk("rs_pre_level", 32'(fifo_level), 2);
        fb = frame_log.size();
        #1;
        rstb = 1'b0;
        #1;
        chk("rs_ser_out", 32'(ser_out), 0);
        chk("rs_ser_frame", 32'(ser_frame), 0);
        chk("rs_level", 32'(fifo_level), 0);
        chk("rs_busy", 32'(busy), 0);
        @(posedge clk_master);
        @(posedge clk_master);
        #3;
        rstb       = 1'b1;
        bank_valid = 6'b111111;
        tick();
        chk("rs_first_grant_b0", 32'(bank_ack), 32'h01);
        bank_valid = '0;
        tick();
        chk("rs_no_partial_frame", 32'(frame_log.size()), 32'(fb));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unison_readout_arbiter.md
# unison_readout_arbiter

Round-robin readout scheduler that shares one serial output pin between the `digital_unison` banks of the cochlea array. Each bank presents a 4-bit sample (`read_out_I[1:0]`, `read_out_Q[1:0]`) with a valid flag. The arbiter grants banks in round-robin order and buffers the granted samples, each tagged with its bank ID, in a small FIFO. A serializer then emits each buffered sample as a fixed 10-bit frame on a GPIO. It sits in `user_project_wrapper` between the bank `read_out_*` outputs and `io_out`, and replaces the current direct logic-analyzer readout.

## Interface
- `NUM_BANKS`, default 6: number of requesting banks. Legal range is 1..8.
- `FIFO_DEPTH`, default 4: sample FIFO entries. Must be a power of 2, minimum 2.
- `clk_master`, in, 1: single clock. All logic is rising-edge.
- `rstb`, in, 1: reset, asynchronous and active-low.
- `en`, in, 1: grant enable, driven from a `la_data_in` bit.
- `bank_valid`, in, NUM_BANKS: bank k has a sample pending.
- `bank_data`, in, 4*NUM_BANKS: sample for bank k at `[4k+3:4k]`, ordered `{I[1:0],Q[1:0]}`.
- `bank_ack`, out, NUM_BANKS: one-cycle registered grant pulse.
- `ser_out`, out, 1: serial frame data.
- `ser_frame`, out, 1: high for every frame bit.
- `fifo_level`, out, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `busy`, out, 1: high when the FIFO is non-empty or a frame is in flight.

## Operation
- **Reset value of every output is 0.** This covers `bank_ack`, `ser_out`, `ser_frame`, `fifo_level` and `busy`. The round-robin pointer resets to bank 0 and the serializer resets to IDLE.
- **Grant condition.** A grant fires on an edge when all of the following hold: `en` is 1, the registered FIFO is not full, and some bank is eligible.
- **Eligible bank.** A bank is eligible when `bank_valid[k]` is 1 and `bank_ack[k]` is 0. Masking banks whose ack is currently high prevents a double grant.
- **Grant choice.** The granted bank g is the first eligible bank at or after the pointer, wrapping modulo NUM_BANKS.
- **Grant effects.** On that edge:
  - `{g[2:0], bank_data[g]}` is written into the FIFO.
  - `bank_ack[g]` goes high for exactly one cycle.
  - The pointer becomes g+1; the pointer after bank NUM_BANKS-1 is 0.
- **Bank handshake.** A bank holds `valid` and `data` stable until it sees its ack, then drops `valid` or presents its next sample. At most one grant is made per cycle.
- **`en` = 0.** No grants are made. The FIFO still drains and any frame in flight completes.
- **Full FIFO.** No grant is made, so banks stall. There is no same-cycle full-write bypass.
- **Empty FIFO.** There is no same-cycle write-to-pop bypass.
- **Serializer states: IDLE and SHIFT.**
  - IDLE to SHIFT when the FIFO is non-empty: pop the head and load the 10-bit frame.
  - Frame bits, MSB first: start `1`, ID[2:0], I1, I0, Q1, Q0, even parity over ID and data, stop `0`.
  - In SHIFT, one bit is emitted per cycle and `ser_frame` is 1.
  - On the stop bit: if the FIFO is non-empty, pop and reload so the next start bit follows with no gap. Otherwise return to IDLE.
  - In IDLE, `ser_out` and `ser_frame` are both 0.
- **Simultaneous grant-write and serializer pop.** Both proceed in the same cycle and `fifo_level` is unchanged.
- **Reset mid-operation.** `rstb` low clears all state immediately and asynchronously. A partial frame is truncated and buffered samples are discarded.

## Timing
- **Grant to ack.** When `valid` is sampled at edge E0 and the FIFO is not full, `bank_ack` is high between E0 and E1.
- **Write to start bit.** With an empty FIFO and an IDLE serializer, the FIFO write happens at E0, the pop at E1, and the start bit appears on `ser_out` from E1 to E2. The stop bit is driven from E10 to E11.
- **Throughput.**
  - Serializer sustained: one frame per 10 cycles.
  - Arbiter peak: one grant per cycle, so the FIFO absorbs bursts.
- `fifo_level` and `busy` are registered and update on the edge of the write or pop.

## Structure
- **Package `unison_pkg`:**
  - `FRAME_LEN` = 10
  - `ID_W` = 3
  - `SAMPLE_W` = 4
  - `START_BIT` = 1
  - `STOP_BIT` = 0
  - serializer state enum {IDLE, SHIFT}
- **Sub-module `unison_sample_fifo`:** synchronous FIFO, width ID_W+SAMPLE_W, with `push`, `pop`, `full`, `empty` and `level`.
- **Top level:** the arbiter and serializer stay in `unison_readout_arbiter`.

## Test plan
- **Single bank.** Bank 3 valid with data 4'b1011, `en` = 1 → `bank_ack[3]` pulses once; frame is `1 011 1011 1 0` (parity 1 for 5 ones); `busy` falls after the stop bit.
- **Round robin.** All 6 banks held valid, `en` = 1 → ack order 0,1,2,3,4,5,0; emitted frame IDs follow the same order.
- **Backpressure.** All banks valid, serializer running, FIFO_DEPTH = 4 → `fifo_level` saturates at 4; no ack while full; the next ack comes one cycle after a pop.
- **Back-to-back frames.** Two samples queued → 20 consecutive cycles of `ser_frame` = 1 with no idle gap.
- **Enable low.** `en` = 0 with banks valid and 2 samples queued → no acks; both queued frames still emitted; grants resume from the current pointer when `en` = 1.
- **Reset mid-frame.** `rstb` pulsed low during frame bit 5 → `ser_out`, `ser_frame`, `fifo_level` and `busy` go 0 immediately; after release, the first grant goes to bank 0.
